// File: rtl/equalizer_wrapper.sv
// Single-tap complex equalizer: each frame's first sample is the reference h, and every
// sample of the frame is multiplied by conj(h), rounded, shifted and saturated over two stages.
module equalizer_wrapper #(
    parameter int DATA_W = 16,
    parameter int NSAMP  = 4,
    parameter int ID_W   = 8,
    parameter int USER_W = 8,
    parameter int SHIFT  = 15
) (
    input  logic                       s_axis_aclk_0,
    input  logic                       s_axis_areset_0,
    input  logic [2*DATA_W*NSAMP-1:0]  s_axis_0_tdata,
    input  logic [ID_W-1:0]            s_axis_0_tid,
    input  logic                       s_axis_0_tlast,
    input  logic [USER_W-1:0]          s_axis_0_tuser,
    input  logic                       s_axis_0_tvalid,
    output logic [2*DATA_W*NSAMP-1:0]  m_axis_0_tdata,
    output logic [ID_W-1:0]            m_axis_0_tid,
    output logic                       m_axis_0_tlast,
    output logic [USER_W-1:0]          m_axis_0_tuser,
    output logic                       m_axis_0_tvalid
);

    // Handshake: valid-only streams, no backpressure. Every edge with s_axis_0_tvalid=1
    // consumes a beat; m_axis_0_tvalid=1 marks exactly one result beat, two edges later.

    localparam int TW = 2 * DATA_W * NSAMP;
    localparam int PW = 2 * DATA_W + 1;
    localparam int RW = PW + 1;
    localparam logic signed [RW-1:0] HALF = RW'(2 ** (SHIFT - 1));
    localparam logic signed [RW-1:0] MAXV = RW'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [RW-1:0] MINV = RW'(-(2 ** (DATA_W - 1)));

    function automatic logic signed [PW-1:0] cmac(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b,
        input logic signed [DATA_W-1:0] c,
        input logic signed [DATA_W-1:0] d,
        input logic                     sub
    );
        logic signed [PW-1:0] ab;
        logic signed [PW-1:0] cd;
        ab = PW'(a) * PW'(b);
        cd = PW'(c) * PW'(d);
        return sub ? (ab - cd) : (ab + cd);
    endfunction

    function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [PW-1:0] p);
        logic signed [RW-1:0] r;
        logic signed [DATA_W-1:0] res;
        r = (RW'(p) + HALF) >>> SHIFT;
        if (r > MAXV) begin
            res = MAXV[DATA_W-1:0];
        end else if (r < MINV) begin
            res = MINV[DATA_W-1:0];
        end else begin
            res = r[DATA_W-1:0];
        end
        return res;
    endfunction

    logic                     frame_start;
    logic signed [DATA_W-1:0] ref_i;
    logic signed [DATA_W-1:0] ref_q;
    logic signed [DATA_W-1:0] use_i;
    logic signed [DATA_W-1:0] use_q;

    logic signed [PW-1:0] prod_i_c [NSAMP];
    logic signed [PW-1:0] prod_q_c [NSAMP];
    logic signed [PW-1:0] prod_i   [NSAMP];
    logic signed [PW-1:0] prod_q   [NSAMP];

    logic              s1_valid;
    logic              s1_last;
    logic [ID_W-1:0]   s1_id;
    logic [USER_W-1:0] s1_user;
    logic [TW-1:0]     res_c;

    // The capturing beat is equalized with its own sample 0, not the stale reference.
    always_comb begin
        use_i = ref_i;
        use_q = ref_q;
        if (frame_start) begin
            use_i = s_axis_0_tdata[DATA_W-1:0];
            use_q = s_axis_0_tdata[2*DATA_W-1:DATA_W];
        end
    end

    always_comb begin
        for (int k = 0; k < NSAMP; k++) begin
            prod_i_c[k] = cmac(s_axis_0_tdata[2*DATA_W*k +: DATA_W], use_i,
                               s_axis_0_tdata[2*DATA_W*k+DATA_W +: DATA_W], use_q, 1'b0);
            prod_q_c[k] = cmac(s_axis_0_tdata[2*DATA_W*k+DATA_W +: DATA_W], use_i,
                               s_axis_0_tdata[2*DATA_W*k +: DATA_W], use_q, 1'b1);
        end
    end

    // frame_start simply follows tlast of each accepted beat, which also covers single-beat frames.
    always_ff @(posedge s_axis_aclk_0) begin
        if (s_axis_areset_0) begin
            frame_start <= 1'b1;
            ref_i       <= '0;
            ref_q       <= '0;
        end else if (s_axis_0_tvalid) begin
            frame_start <= s_axis_0_tlast;
            if (frame_start) begin
                ref_i <= use_i;
                ref_q <= use_q;
            end
        end
    end

    always_ff @(posedge s_axis_aclk_0) begin
        if (s_axis_areset_0) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_id    <= '0;
            s1_user  <= '0;
            for (int k = 0; k < NSAMP; k++) begin
                prod_i[k] <= '0;
                prod_q[k] <= '0;
            end
        end else begin
            s1_valid <= s_axis_0_tvalid;
            if (s_axis_0_tvalid) begin
                s1_last <= s_axis_0_tlast;
                s1_id   <= s_axis_0_tid;
                s1_user <= s_axis_0_tuser;
                for (int k = 0; k < NSAMP; k++) begin
                    prod_i[k] <= prod_i_c[k];
                    prod_q[k] <= prod_q_c[k];
                end
            end
        end
    end

    always_comb begin
        res_c = '0;
        for (int k = 0; k < NSAMP; k++) begin
            res_c[2*DATA_W*k +: DATA_W]        = round_sat(prod_i[k]);
            res_c[2*DATA_W*k+DATA_W +: DATA_W] = round_sat(prod_q[k]);
        end
    end

    // Output registers only load on valid, so they hold the last result across gaps.
    always_ff @(posedge s_axis_aclk_0) begin
        if (s_axis_areset_0) begin
            m_axis_0_tvalid <= 1'b0;
            m_axis_0_tdata  <= '0;
            m_axis_0_tid    <= '0;
            m_axis_0_tlast  <= 1'b0;
            m_axis_0_tuser  <= '0;
        end else begin
            m_axis_0_tvalid <= s1_valid;
            if (s1_valid) begin
                m_axis_0_tdata <= res_c;
                m_axis_0_tid   <= s1_id;
                m_axis_0_tlast <= s1_last;
                m_axis_0_tuser <= s1_user;
            end
        end
    end

endmodule

// File: tb/tb_equalizer_wrapper.sv
// Bench for equalizer_wrapper: directed and random beats are scored against an
// integer-arithmetic model of the per-frame conjugate multiply, with a due-cycle queue.
module tb_equalizer_wrapper;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] s_tdata;
    logic [7:0]   s_tid;
    logic         s_tlast;
    logic [7:0]   s_tuser;
    logic         s_tvalid;
    logic [127:0] m_tdata;
    logic [7:0]   m_tid;
    logic         m_tlast;
    logic [7:0]   m_tuser;
    logic         m_tvalid;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    equalizer_wrapper dut (
        .s_axis_aclk_0   (clk),
        .s_axis_areset_0 (rst),
        .s_axis_0_tdata  (s_tdata),
        .s_axis_0_tid    (s_tid),
        .s_axis_0_tlast  (s_tlast),
        .s_axis_0_tuser  (s_tuser),
        .s_axis_0_tvalid (s_tvalid),
        .m_axis_0_tdata  (m_tdata),
        .m_axis_0_tid    (m_tid),
        .m_axis_0_tlast  (m_tlast),
        .m_axis_0_tuser  (m_tuser),
        .m_axis_0_tvalid (m_tvalid)
    );

    // ---------------- scoreboard state ----------------
    logic [127:0] exp_q[$];
    logic [16:0]  exp_side_q[$];
    int           exp_due_q[$];
    int           n_checks = 0;
    int           n_fail = 0;
    bit           armed = 1'b0;
    int           zero_until = -1;
    int           model_hi = 0;
    int           model_hq = 0;
    bit           model_fs = 1'b1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] scale(input longint v);
        longint t;
        longint q;
        t = v + 16384;
        if (t >= 0) q = t / 32768;
        else        q = -((-t + 32767) / 32768);
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return 16'(q);
    endfunction

    function automatic logic [127:0] equalize(input logic [127:0] d, input int hi, input int hq);
        logic [127:0] r;
        longint xi;
        longint xq;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            xi = longint'($signed(d[32*k +: 16]));
            xq = longint'($signed(d[32*k+16 +: 16]));
            r[32*k +: 16]    = scale(xi * hi + xq * hq);
            r[32*k+16 +: 16] = scale(xq * hi - xi * hq);
        end
        return r;
    endfunction

    function automatic logic [127:0] set_lane(input logic [127:0] d, input int k, input int i, input int q);
        logic [127:0] r;
        r = d;
        r[32*k +: 16]    = 16'(i);
        r[32*k+16 +: 16] = 16'(q);
        return r;
    endfunction

    function automatic logic [127:0] rnd_beat();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- monitor + driver ----------------
    task automatic check_outputs();
        bit due;
        if (!armed) return;
        if (cyc <= zero_until) begin
            chk("reset_tdata", m_tdata, 128'd0);
            chk("reset_side", {m_tlast, m_tid, m_tuser}, 128'd0);
            chk("reset_tvalid", m_tvalid, 128'd0);
        end
        due = (exp_due_q.size() != 0) && (exp_due_q[0] == cyc);
        chk("tvalid", m_tvalid, due);
        if (due) begin
            void'(exp_due_q.pop_front());
            chk("tdata", m_tdata, exp_q.pop_front());
            chk("sideband", {m_tlast, m_tid, m_tuser}, exp_side_q.pop_front());
        end
    endtask

    task automatic step(input logic v, input logic [127:0] d, input logic [7:0] id,
                        input logic [7:0] user, input logic last, input logic r);
        @(negedge clk);
        check_outputs();
        s_tvalid = v;
        s_tdata  = d;
        s_tid    = id;
        s_tuser  = user;
        s_tlast  = last;
        rst      = r;
        if (r) begin
            exp_q.delete();
            exp_side_q.delete();
            exp_due_q.delete();
            model_fs   = 1'b1;
            model_hi   = 0;
            model_hq   = 0;
            zero_until = cyc + 2;
            armed      = 1'b1;
        end else if (v) begin
            if (model_fs) begin
                model_hi = int'($signed(d[15:0]));
                model_hq = int'($signed(d[31:16]));
            end
            model_fs = last;
            exp_q.push_back(equalize(d, model_hi, model_hq));
            exp_side_q.push_back({last, id, user});
            exp_due_q.push_back(cyc + 2);
        end
    endtask

    task automatic idle();
        step(1'b0, rnd_beat(), 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] d;
        rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tid = '0; s_tuser = '0; s_tlast = 1'b0;
        repeat (3) step(1'b0, 128'd0, 8'h00, 8'h00, 1'b0, 1'b1);
        repeat (2) idle();

        // single beat, unity-half reference
        d = rnd_beat(); d = set_lane(d, 0, 16384, 0); d = set_lane(d, 1, 1000, -2000);
        step(1'b1, d, 8'h11, 8'h22, 1'b1, 1'b0);
        repeat (3) idle();

        // reference on the Q axis rotates later beats of the frame
        d = rnd_beat(); d = set_lane(d, 0, 0, 16384);
        step(1'b1, d, 8'h01, 8'h02, 1'b0, 1'b0);
        d = rnd_beat(); d = set_lane(d, 2, 1000, 0);
        step(1'b1, d, 8'h03, 8'h04, 1'b1, 1'b0);
        repeat (2) idle();

        // saturation on lane 3
        d = rnd_beat(); d = set_lane(d, 0, -32768, -32768); d = set_lane(d, 3, -32768, -32768);
        step(1'b1, d, 8'h05, 8'h06, 1'b1, 1'b0);
        idle();

        // rounding with h=(1,0)
        d = rnd_beat(); d = set_lane(d, 0, 1, 0); d = set_lane(d, 1, 16384, 0);
        step(1'b1, d, 8'h07, 8'h08, 1'b0, 1'b0);
        d = rnd_beat(); d = set_lane(d, 1, 16383, 0);
        step(1'b1, d, 8'h09, 8'h0A, 1'b0, 1'b0);
        d = rnd_beat(); d = set_lane(d, 1, -16385, 0);
        step(1'b1, d, 8'h0B, 8'h0C, 1'b1, 1'b0);
        idle();

        // back-to-back frame boundary forces recapture
        d = rnd_beat(); d = set_lane(d, 0, 16384, 0);
        step(1'b1, d, 8'h5A, 8'h3C, 1'b1, 1'b0);
        d = rnd_beat(); d = set_lane(d, 0, 0, 16384); d = set_lane(d, 1, 1000, 0);
        step(1'b1, d, 8'h5A, 8'h3C, 1'b0, 1'b0);
        // tlast without tvalid is ignored, so this beat keeps the current reference
        step(1'b0, rnd_beat(), 8'h00, 8'h00, 1'b1, 1'b0);
        step(1'b1, rnd_beat(), 8'h77, 8'h78, 1'b1, 1'b0);

        // random gaps and frame lengths
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), rnd_beat(), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), 1'b0);
        end

        // continuous stream with a one-cycle reset in the middle
        for (int i = 0; i < 320; i++) begin
            step(1'b1, rnd_beat(), 8'(i), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 15) == 0), (i == 160));
        end
        repeat (4) idle();

        chk("drained", exp_q.size(), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/equalizer_wrapper.md
Name: equalizer_wrapper

Overview:
- Streaming single-tap complex phase/gain equalizer at the top of the receive equalizer design.
- Accepts an AXI-Stream of 4 complex 16-bit samples per beat.
- Captures a per-frame reference (pilot) from the first sample of each frame and multiplies every sample of that frame by the reference's complex conjugate, with scaling, rounding and saturation.
- Emits an aligned AXI-Stream with sideband fields delayed identically.

Parameters:
- DATA_W, 16, bit width of each I and Q component.
- NSAMP, 4, complex samples per beat; tdata width is 2*DATA_W*NSAMP = 128.
- ID_W, 8, tid width.
- USER_W, 8, tuser width.
- SHIFT, 15, arithmetic right shift applied to products (Q1.15 reference).

Ports:
- s_axis_aclk_0  in  1  single clock, all logic rising-edge.
- s_axis_areset_0  in  1  synchronous active-high reset.
- s_axis_0_tdata  in  128  sample k: I at [32k+15:32k], Q at [32k+31:32k+16], two's complement, k=0..3.
- s_axis_0_tid  in  8  stream id, passed through.
- s_axis_0_tlast  in  1  last beat of frame.
- s_axis_0_tuser  in  8  user sideband, passed through.
- s_axis_0_tvalid  in  1  beat valid; there is no tready, so the block always accepts.
- m_axis_0_tdata  out  128  equalized samples, same packing as input.
- m_axis_0_tid  out  8  delayed tid.
- m_axis_0_tlast  out  1  delayed tlast.
- m_axis_0_tuser  out  8  delayed tuser.
- m_axis_0_tvalid  out  1  output valid.

Behaviour:
- Reset (synchronous, active-high, checked each rising edge):
  - All outputs go to 0; reference h := (0,0).
  - Pipeline valids are cleared.
  - frame_start flag := 1.
- Input sampling: tdata, tid, tlast and tuser are sampled only on edges where tvalid=1. A tlast pulse with tvalid=0 is ignored.
- Reference capture: on an accepted beat with frame_start=1:
  - h := sample 0 of that beat.
  - frame_start := 0.
  - That same beat is equalized with the new h (bypass; the previous h is not used).
- Frame end: an accepted beat with tlast=1 sets frame_start := 1 after that beat, so the next accepted beat recaptures h.
- Arithmetic, per sample x=(xi,xq), h=(hi,hq), 4 lanes in parallel:
  - pi = xi*hi + xq*hq, 33-bit signed.
  - pq = xq*hi − xi*hq, 33-bit signed.
  - Round: add 2^(SHIFT−1), then arithmetic shift right by SHIFT.
  - Saturate to [−32768, 32767].
- Latency: exactly 2 cycles from an accepted input beat to m_axis_0_tvalid=1 with its result.
  - Stage 1 registers products.
  - Stage 2 registers the rounded/saturated result.
- tid, tuser and tlast travel with the data through both stages.
- Throughput: one beat per cycle, back-to-back, no bubbles inserted.
- Gaps: when tvalid=0, m_axis_0_tvalid=0 two cycles later.
  - Output data/sideband hold their last value while invalid.
  - Output contents are don't-care when tvalid=0.
- Reset mid-frame:
  - Discards both pipeline stages; no output valid appears for beats in flight.
  - The next accepted beat after reset recaptures h.
- Simultaneous tlast=1 and frame_start=1 (single-beat frame): capture h, equalize the beat, and frame_start stays 1.
- Lane independence: all lanes use the same h; no cross-lane interaction.

Test Plan:
- Reset, then one beat with sample0=(16384,0) and sample1=(1000,−2000) -> 2 cycles later out lane0=(8192,0), lane1=(500,−1000), tvalid=1 for 1 cycle.
- Frame with first sample (0,16384); later beat lane2=(1000,0) -> output lane2=(0,−500).
- Saturation: reference (−32768,−32768), lane3=(−32768,−32768) -> output lane3=(32767,0).
- Rounding: reference (1,0):
  - lane1=(16384,0) -> (1,0).
  - lane1=(16383,0) -> (0,0).
  - lane1=(−16385,0) -> (−1,0).
- Frame boundary:
  - Beat A, tlast=1, h from (16384,0).
  - Next beat B has sample0=(0,16384) and lane1=(1000,0) -> B output lane1=(0,−500), proving recapture.
  - tlast, tid=0x5A and tuser=0x3C emerge aligned with their data, 2 cycles later.
- Continuous stream of 320 beats with tvalid held high, reset asserted for 1 cycle mid-stream -> outputs 0 and tvalid=0 for 2 cycles, then valid outputs resume using the h recaptured from the first post-reset beat.
